// File: rtl/multiport_register_bank_pkg.sv
// Shared definitions for the multiport register bank: controller states and
// the supported range of read-port counts.
package multiport_register_bank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int READ_PORTS_MIN = 1;
  localparam int READ_PORTS_MAX = 4;

endpackage

// File: rtl/multiport_register_bank_read_port.sv
// One combinational read port: array select with zero-register, write-bypass
// and not-ready gating.
module register_bank_read_port #(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic [REGISTER_WIDTH-1:0] i_mem [2**BANK_WIDTH],
  input  logic [BANK_WIDTH-1:0]     i_sel,
  input  logic                      i_ready,
  input  logic                      i_byp_en,
  input  logic [BANK_WIDTH-1:0]     i_wr_sel,
  input  logic [REGISTER_WIDTH-1:0] i_wr_data,
  output logic [REGISTER_WIDTH-1:0] o_data
);

  // Priority: not ready, then hardwired zero, then forwarding, then storage.
  always_comb begin
    o_data = {REGISTER_WIDTH{1'b0}};
    if (!i_ready) begin
      o_data = {REGISTER_WIDTH{1'b0}};
    end else if ((ZERO_REG != 0) && (i_sel == {BANK_WIDTH{1'b0}})) begin
      o_data = {REGISTER_WIDTH{1'b0}};
    end else if ((BYPASS != 0) && i_byp_en && (i_sel == i_wr_sel)) begin
      o_data = i_wr_data;
    end else begin
      o_data = i_mem[i_sel];
    end
  end

endmodule

// File: rtl/multiport_register_bank.sv
// Register bank with one write port, N combinational read ports and a
// sweep-based clear controller that zeroes the array after reset or clr.
module multiport_register_bank
  import multiport_register_bank_pkg::*;
#(
  parameter int BANK_WIDTH     = 5,
  parameter int REGISTER_WIDTH = 32,
  parameter int READ_PORTS     = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [READ_PORTS*BANK_WIDTH-1:0]   rs_sel,
  output logic [READ_PORTS*REGISTER_WIDTH-1:0] rs_data,
  input  logic [BANK_WIDTH-1:0]              rd_sel,
  input  logic [REGISTER_WIDTH-1:0]          rd_data,
  input  logic                               reg_w,
  output logic                               ready,
  output logic                               wr_drop
);

  localparam int SIZE = 2**BANK_WIDTH;
  localparam logic [BANK_WIDTH:0] LAST_IDX = (BANK_WIDTH+1)'(SIZE-1);

  if ((READ_PORTS < READ_PORTS_MIN) || (READ_PORTS > READ_PORTS_MAX)) begin : g_bad_ports
    $error("multiport_register_bank: READ_PORTS out of range");
  end

  state_t                    r_state, w_state_nxt;
  logic [BANK_WIDTH:0]       r_idx, w_idx_nxt;
  logic                      r_ready, w_ready_nxt;
  logic                      r_wr_drop, w_wr_drop_nxt;
  logic                      w_we;
  logic [BANK_WIDTH-1:0]     w_waddr;
  logic [REGISTER_WIDTH-1:0] w_wdata;
  logic                      w_byp_en;
  logic [REGISTER_WIDTH-1:0] r_mem [SIZE];

  // Controller state, sweep index and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_CLEAR;
      r_idx     <= {(BANK_WIDTH+1){1'b0}};
      r_ready   <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_ready   <= w_ready_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  // Next-state logic and the single array write port shared by sweep and user.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_ready_nxt   = r_ready;
    w_wr_drop_nxt = 1'b0;
    w_we          = 1'b0;
    w_waddr       = rd_sel;
    w_wdata       = rd_data;
    case (r_state)
      ST_CLEAR: begin
        w_we          = 1'b1;
        w_waddr       = r_idx[BANK_WIDTH-1:0];
        w_wdata       = {REGISTER_WIDTH{1'b0}};
        w_wr_drop_nxt = reg_w;
        w_idx_nxt     = r_idx + {{BANK_WIDTH{1'b0}}, 1'b1};
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_READY;
          w_ready_nxt = 1'b1;
        end else begin
          w_ready_nxt = 1'b0;
        end
      end
      ST_READY: begin
        if (clr) begin
          w_state_nxt   = ST_CLEAR;
          w_idx_nxt     = {(BANK_WIDTH+1){1'b0}};
          w_ready_nxt   = 1'b0;
          w_wr_drop_nxt = reg_w;
        end else begin
          w_ready_nxt = 1'b1;
          w_we = reg_w && !((ZERO_REG != 0) && (rd_sel == {BANK_WIDTH{1'b0}}));
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = {(BANK_WIDTH+1){1'b0}};
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Array storage; contents are established by the clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_byp_en = r_ready && !clr && reg_w;
  assign ready    = r_ready;
  assign wr_drop  = r_wr_drop;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd_port
    register_bank_read_port #(
      .BANK_WIDTH    (BANK_WIDTH),
      .REGISTER_WIDTH(REGISTER_WIDTH),
      .ZERO_REG      (ZERO_REG),
      .BYPASS        (BYPASS)
    ) u_port (
      .i_mem    (r_mem),
      .i_sel    (rs_sel[p*BANK_WIDTH +: BANK_WIDTH]),
      .i_ready  (r_ready),
      .i_byp_en (w_byp_en),
      .i_wr_sel (rd_sel),
      .i_wr_data(rd_data),
      .o_data   (rs_data[p*REGISTER_WIDTH +: REGISTER_WIDTH])
    );
  end

endmodule

// File: tb/tb_multiport_register_bank.sv
// Directed bench for the register bank: one forwarding and one non-forwarding
// instance driven in parallel, expected values queued and checked in order.
module tb_multiport_register_bank;

  logic        clk = 1'b0;
  logic        rst, clr, reg_w;
  logic [14:0] rs_sel;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic [95:0] rs_data_a, rs_data_b;
  logic        ready_a, ready_b, wr_drop_a, wr_drop_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  multiport_register_bank #(
    .BANK_WIDTH(5), .REGISTER_WIDTH(32), .READ_PORTS(3), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .rs_sel(rs_sel), .rs_data(rs_data_a),
    .rd_sel(rd_sel), .rd_data(rd_data), .reg_w(reg_w), .ready(ready_a), .wr_drop(wr_drop_a)
  );

  multiport_register_bank #(
    .BANK_WIDTH(5), .REGISTER_WIDTH(32), .READ_PORTS(3), .ZERO_REG(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .rs_sel(rs_sel), .rs_data(rs_data_b),
    .rd_sel(rd_sel), .rd_data(rd_data), .reg_w(reg_w), .ready(ready_b), .wr_drop(wr_drop_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [127:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_val(input logic [127:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [95:0] rep3(input logic [31:0] v);
    return {v, v, v};
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_a && n < 64);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    rd_sel  = a;
    rd_data = d;
    reg_w   = 1'b1;
    tick();
    reg_w   = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0; clr = 1'b0; reg_w = 1'b0;
    rs_sel = 15'd0; rd_sel = 5'd0; rd_data = 32'd0;
    tick(); tick();

    expect_val("rst_ready", 128'd0);   check_val({127'd0, ready_a});
    expect_val("rst_wr_drop", 128'd0); check_val({127'd0, wr_drop_a});
    expect_val("rst_rs_data", 128'd0); check_val({32'd0, rs_data_a});

    rst = 1'b1;
    wait_ready(n);
    expect_val("init_sweep_edges", 128'd32); check_val(128'(n));
    expect_val("init_ready_b", 128'd1);      check_val({127'd0, ready_b});
    for (int a = 0; a < 32; a++) begin
      rs_sel = {3{a[4:0]}};
      #1;
      expect_val($sformatf("init_zero_a_r%0d", a), 128'd0); check_val({32'd0, rs_data_a});
      expect_val($sformatf("init_zero_b_r%0d", a), 128'd0); check_val({32'd0, rs_data_b});
    end
    tick();

    do_write(5'd5, 32'hDEADBEEF);
    rs_sel = {3{5'd5}};
    #1;
    expect_val("r5_all_ports_a", {32'd0, rep3(32'hDEADBEEF)}); check_val({32'd0, rs_data_a});
    expect_val("r5_all_ports_b", {32'd0, rep3(32'hDEADBEEF)}); check_val({32'd0, rs_data_b});

    rd_sel = 5'd0; rd_data = 32'h00001234; reg_w = 1'b1; rs_sel = {3{5'd0}};
    #1;
    expect_val("r0_no_bypass_a", 128'd0); check_val({32'd0, rs_data_a});
    tick();
    reg_w = 1'b0;
    expect_val("r0_no_wr_drop", 128'd0); check_val({127'd0, wr_drop_a});
    #1;
    expect_val("r0_reads_zero_a", 128'd0); check_val({32'd0, rs_data_a});
    expect_val("r0_reads_zero_b", 128'd0); check_val({32'd0, rs_data_b});

    do_write(5'd7, 32'h11111111);
    rd_sel = 5'd7; rd_data = 32'hA5A5A5A5; reg_w = 1'b1;
    rs_sel = {5'd5, 5'd7, 5'd0};
    #1;
    expect_val("bypass_on_port1", {32'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'd0});
    check_val({32'd0, rs_data_a});
    expect_val("bypass_off_old", {32'd0, 32'hDEADBEEF, 32'h11111111, 32'd0});
    check_val({32'd0, rs_data_b});
    tick();
    reg_w = 1'b0;
    #1;
    expect_val("bypass_off_new", {32'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 32'd0});
    check_val({32'd0, rs_data_b});

    do_write(5'd3, 32'hCAFEF00D);
    rs_sel = {3{5'd3}};
    #1;
    expect_val("r3_written", {32'd0, rep3(32'hCAFEF00D)}); check_val({32'd0, rs_data_a});

    clr = 1'b1; reg_w = 1'b1; rd_sel = 5'd3; rd_data = 32'h33333333;
    tick();
    clr = 1'b0; reg_w = 1'b0;
    expect_val("clr_ready_low", 128'd0);     check_val({127'd0, ready_a});
    expect_val("clr_wr_drop", 128'd1);       check_val({127'd0, wr_drop_a});
    expect_val("clr_rs_data_gated", 128'd0); check_val({32'd0, rs_data_a});
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        expect_val("clr_wr_drop_one_cycle", 128'd0); check_val({127'd0, wr_drop_a});
      end
    end while (!ready_a && n < 64);
    expect_val("clr_sweep_edges", 128'd32); check_val(128'(n));
    rs_sel = {5'd5, 5'd7, 5'd3};
    #1;
    expect_val("clr_contents_zero_a", 128'd0); check_val({32'd0, rs_data_a});
    expect_val("clr_contents_zero_b", 128'd0); check_val({32'd0, rs_data_b});
    tick();

    rst = 1'b0;
    #1;
    expect_val("async_rst_ready", 128'd0);   check_val({127'd0, ready_a});
    expect_val("async_rst_rs_data", 128'd0); check_val({32'd0, rs_data_a});
    tick();
    rst = 1'b1;
    wait_ready(n);
    expect_val("rst_release_edges", 128'd32); check_val(128'(n));

    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    #1;
    expect_val("mid_sweep_rst_ready", 128'd0); check_val({127'd0, ready_a});
    tick();
    rst = 1'b1;
    wait_ready(n);
    expect_val("mid_sweep_restart_edges", 128'd32); check_val(128'(n));

    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 20) begin
        reg_w = 1'b1; rd_sel = 5'd2; rd_data = 32'h22222222;
      end else if (n == 21) begin
        reg_w = 1'b0;
        expect_val("clear_write_drop", 128'd1); check_val({127'd0, wr_drop_a});
      end else if (n == 22) begin
        expect_val("clear_write_drop_end", 128'd0); check_val({127'd0, wr_drop_a});
      end
    end while (!ready_a && n < 64);
    expect_val("clear_write_sweep_edges", 128'd32); check_val(128'(n));
    rs_sel = {3{5'd2}};
    #1;
    expect_val("clear_write_ignored_a", 128'd0); check_val({32'd0, rs_data_a});
    expect_val("clear_write_ignored_b", 128'd0); check_val({32'd0, rs_data_b});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
